uart_link: RTL and testbench

- Byte-oriented full-duplex UART transceiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first.
- Buffered by a TX FIFO and an RX FIFO; client side uses flag/ready handshakes.
- Sits under the multi-channel message layer, which pushes bytes through send_flag/send_data and pops them through recv_flag/recv_data.
- Bit period is a whole number of system clocks, set by parameter.

---
 rtl/uart_link_pkg.sv | 19 +
 rtl/uart_link_fifo.sv | 46 ++++
 rtl/uart_link.sv | 198 +++++++++++++++++++
 tb/tb_uart_link.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the uart_link transceiver.
// Holds the FSM state encoding, the frame data width and the bit-counter sizing function.
package uart_link_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic int cnt_width(input int interval);
        return $clog2(interval) + 1;
    endfunction

endpackage

// File: rtl/uart_link_fifo.sv
// Byte FIFO with show-ahead head and registered not_full / not_empty flags.
// Latency: a push is visible on head one cycle later. Backpressure: a push when full or a pop when empty is ignored.
module uart_link_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       not_full,
    output logic       not_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic                do_push, do_pop;

    assign do_push = push && not_full;
    assign do_pop  = pop && not_empty;
    assign wr_next = wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
    assign rd_next = rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            not_full  <= 1'b1;
            not_empty <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            not_empty <= (wr_next != rd_next);
            not_full  <= (wr_next[DEPTH_LOG2-1:0] != rd_next[DEPTH_LOG2-1:0]) ||
                         (wr_next[DEPTH_LOG2] == rd_next[DEPTH_LOG2]);
        end
    end

endmodule

// File: rtl/uart_link.sv
// Full-duplex 8N1 UART behind TX/RX byte FIFOs; UART_PARITY_EN switches the frame to 8E1.
// Latency: send_flag to Tx falling edge is 2 clocks when idle. Backpressure: sendable/recvable gate pushes and pops.
module uart_link
    import uart_link_pkg::*;
#(
    parameter int SAMPLE_INTERVAL = 868,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_flag,
    input  logic [7:0] send_data,
    input  logic       recv_flag,
    output logic [7:0] recv_data,
    output logic       sendable,
    output logic       recvable,
    output logic       Tx,
    input  logic       Rx
);

    localparam int            CW       = cnt_width(SAMPLE_INTERVAL);
    localparam logic [CW-1:0] BIT_END  = CW'(SAMPLE_INTERVAL - 1);
    localparam logic [CW-1:0] HALF_END = CW'(SAMPLE_INTERVAL / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic [7:0] tx_head;
    logic       tx_not_empty, tx_pop;
    state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;
`ifdef UART_PARITY_EN
    logic       tx_par;
    logic       rx_bad;
`endif

    logic       rx_s1, rx_s2;
    state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [7:0] rx_shift;
    logic [2:0] rx_bit;
    logic       rx_err, rx_push;

    uart_link_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(send_flag), .push_data(send_data),
        .pop(tx_pop), .head(tx_head), .not_full(sendable), .not_empty(tx_not_empty)
    );

    uart_link_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift),
        .pop(recv_flag), .head(recv_data), .not_full(), .not_empty(recvable)
    );

    assign tx_pop = (tx_state == ST_IDLE) && tx_not_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            Tx       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                ST_IDLE: if (tx_not_empty) begin
                    tx_state <= ST_START;
                    tx_cnt   <= '0;
                    tx_shift <= tx_head;
                    tx_bit   <= '0;
                    Tx       <= 1'b0;
`ifdef UART_PARITY_EN
                    tx_par   <= ^tx_head;
`endif
                end
                ST_START: if (tx_cnt == BIT_END) begin
                    tx_state <= ST_DATA;
                    tx_cnt   <= '0;
                    Tx       <= tx_shift[0];
                end else tx_cnt <= tx_cnt + CNT_ONE;
                ST_DATA: if (tx_cnt == BIT_END) begin
                    tx_cnt <= '0;
                    if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state <= ST_PARITY;
                        Tx       <= tx_par;
`else
                        tx_state <= ST_STOP;
                        Tx       <= 1'b1;
`endif
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        Tx       <= tx_shift[1];
                    end
                end else tx_cnt <= tx_cnt + CNT_ONE;
`ifdef UART_PARITY_EN
                ST_PARITY: if (tx_cnt == BIT_END) begin
                    tx_state <= ST_STOP;
                    tx_cnt   <= '0;
                    Tx       <= 1'b1;
                end else tx_cnt <= tx_cnt + CNT_ONE;
`endif
                ST_STOP: if (tx_cnt == BIT_END) begin
                    tx_state <= ST_IDLE;
                    tx_cnt   <= '0;
                end else tx_cnt <= tx_cnt + CNT_ONE;
                default: begin
                    tx_state <= ST_IDLE;
                    tx_cnt   <= '0;
                    Tx       <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
        end
    end

    // Sampling points sit at mid-bit: half a period after the start edge, then every full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_err   <= 1'b0;
            rx_push  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_bad   <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                ST_IDLE: if (!rx_s2) begin
                    rx_state <= ST_START;
                    rx_cnt   <= '0;
                end
                ST_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                end else rx_cnt <= rx_cnt + CNT_ONE;
                ST_DATA: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state <= ST_PARITY;
`else
                        rx_state <= ST_STOP;
`endif
                    end else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt + CNT_ONE;
`ifdef UART_PARITY_EN
                ST_PARITY: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_bad   <= rx_s2 ^ (^rx_shift);
                    rx_state <= ST_STOP;
                end else rx_cnt <= rx_cnt + CNT_ONE;
`endif
                ST_STOP: if (rx_err) begin
                    if (rx_s2) begin
                        rx_err   <= 1'b0;
                        rx_state <= ST_IDLE;
                        rx_cnt   <= '0;
                    end
                end else if (rx_cnt == BIT_END) begin
                    rx_cnt <= '0;
                    if (!rx_s2) rx_err <= 1'b1;
                    else begin
                        rx_state <= ST_IDLE;
`ifdef UART_PARITY_EN
                        rx_push  <= !rx_bad;
`else
                        rx_push  <= 1'b1;
`endif
                    end
                end else rx_cnt <= rx_cnt + CNT_ONE;
                default: begin
                    rx_state <= ST_IDLE;
                    rx_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// Directed/randomized bench for uart_link with a frame-level serial model and a byte queue scoreboard.
`timescale 1ns/1ps
module tb_uart_link;

    localparam int SI    = 16;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_flag = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       recv_flag = 1'b0;
    logic [7:0] recv_data;
    logic       sendable, recvable, Tx, Rx;
    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    assign Rx = loop_en ? Tx : rx_drv;

    uart_link #(.SAMPLE_INTERVAL(SI), .FIFO_DEPTH_LOG2(3)) dut (
        .clk(clk), .rst(rst), .send_flag(send_flag), .send_data(send_data),
        .recv_flag(recv_flag), .recv_data(recv_data), .sendable(sendable),
        .recvable(recvable), .Tx(Tx), .Rx(Rx)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit k of a well-formed frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FRAME_BITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        send_flag = 1'b1;
        send_data = b;
        @(negedge clk);
        send_flag = 1'b0;
    endtask

    task automatic capture(input string tag, input logic [7:0] b);
        int w = 0;
        while (Tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({tag, " start seen"}, 32'(w < 400), 1);
        repeat (SI / 2) @(negedge clk);
        for (int k = 0; k < FRAME_BITS; k++) begin
            check($sformatf("%s bit%0d", tag, k), Tx, frame_bit(b, k));
            if (k < FRAME_BITS - 1) repeat (SI) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < FRAME_BITS; k++) begin
            rx_drv = (k == FRAME_BITS - 1) ? stop : frame_bit(b, k);
            repeat (SI) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            check({tag, " recvable"}, recvable, 1);
            check({tag, " data"}, recv_data, exp_q.pop_front());
            recv_flag = 1'b1;
            @(negedge clk);
            recv_flag = 1'b0;
        end
        check({tag, " empty"}, recvable, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] burst [10];
        int lat, w, lows;

        repeat (3) @(negedge clk);
        check("rst Tx", Tx, 1);
        check("rst sendable", sendable, 1);
        check("rst recvable", recvable, 0);
        check("rst recv_data", recv_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle Tx", Tx, 1);
            check("idle sendable", sendable, 1);
            check("idle recvable", recvable, 0);
        end

        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            push_byte(b);
            lat = 1;
            while (Tx !== 1'b0 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("tx latency", 32'(lat <= 3), 1);
            capture("single", b);
            repeat (SI) @(negedge clk);
        end

        loop_en = 1'b1;
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        for (int i = 0; i < exp_q.size(); i++) push_byte(exp_q[i]);
        w = 0;
        while (recvable !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("loop first rise", 32'(w < 400), 1);
        check("loop first head", recv_data, exp_q[0]);
        repeat (6 * (FRAME_BITS * SI + 2)) @(negedge clk);
        drain("loop");
        loop_en = 1'b0;
        repeat (SI) @(negedge clk);

        // Idle transmitter takes the first byte at once, so 1 in flight + DEPTH buffered; the tenth is lost.
        for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 10; i++) push_byte(burst[i]);
                check("full sendable", sendable, 0);
            end
            begin
                for (int i = 0; i < DEPTH + 1; i++) capture($sformatf("burst%0d", i), burst[i]);
            end
        join
        lows = 0;
        repeat (3 * FRAME_BITS * SI) begin
            @(negedge clk);
            if (Tx === 1'b0) lows++;
        end
        check("burst no extra frame", lows, 0);
        check("burst sendable back", sendable, 1);

        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch no byte", recvable, 0);
        drive_frame(8'hC3, 1'b0);
        repeat (50) @(negedge clk);
        check("framing no byte", recvable, 0);
        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1);
        drain("after error");

        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            drive_frame(b, 1'b1);
        end
        check("ovf recvable", recvable, 1);
        drain("ovf");

        push_byte(8'h00);
        push_byte(8'h00);
        repeat (40) @(negedge clk);
        check("midframe Tx low", Tx, 0);
        rst = 1'b1;
        #1;
        check("midrst Tx", Tx, 1);
        check("midrst sendable", sendable, 1);
        check("midrst recvable", recvable, 0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (2 * FRAME_BITS * SI) begin
            @(negedge clk);
            if (Tx === 1'b0) lows++;
        end
        check("midrst fifo cleared", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
